result_decoder: RTL

//   Receive-side decoder for the 3-bit muxed result bus (sel=0: dice throw, sel=1: {green,amber,red}).

---
 rtl/result_decoder_if.sv | 34 +++
 rtl/result_decoder.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/result_decoder_if.sv
// Purpose : shared signal bundle between the muxed result bus source and result_decoder.
// Latency : n/a (wires only).
// Backpressure: none; the bus is sampled every cycle.
// Ports (master drives / slave drives):
//   master -> slave : sel, result[2:0], clr_err
//   slave -> master : dice_value[2:0], dice_new, dice_err, light_phase[1:0], light_valid,
//                     seq_err, throw_cnt[CNT_W-1:0], cycle_cnt[CNT_W-1:0]
interface result_decoder_if #(
  parameter int CNT_W = 8
);
  logic             sel;
  logic [2:0]       result;
  logic             clr_err;
  logic [2:0]       dice_value;
  logic             dice_new;
  logic             dice_err;
  logic [1:0]       light_phase;
  logic             light_valid;
  logic             seq_err;
  logic [CNT_W-1:0] throw_cnt;
  logic [CNT_W-1:0] cycle_cnt;

  modport master (
    output sel, result, clr_err,
    input  dice_value, dice_new, dice_err, light_phase, light_valid,
           seq_err, throw_cnt, cycle_cnt
  );

  modport slave (
    input  sel, result, clr_err,
    output dice_value, dice_new, dice_err, light_phase, light_valid,
           seq_err, throw_cnt, cycle_cnt
  );
endinterface

// File: rtl/result_decoder.sv
// Purpose : demux the 3-bit dice/traffic-light bus into a debounced throw and a tracked light phase.
// Latency : light code at edge E -> light_phase at E+1; dice value stable STABLE_CYC edges -> captured next edge.
// Backpressure: none; every cycle is consumed, outputs are registered.
// Ports:
//   i_clk  : rising-edge clock
//   i_rst  : synchronous reset, active-low
//   io_bus : result_decoder_if.slave (sel/result/clr_err in; dice_*, light_*, errors, counters out)
module result_decoder #(
  parameter int CNT_W      = 8,
  parameter int STABLE_CYC = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  result_decoder_if.slave io_bus
);

  typedef enum logic [2:0] {
    ST_UNSYNC,
    ST_RED,
    ST_RED_AMBER,
    ST_GREEN,
    ST_AMBER
  } state_t;

  localparam int RUN_W = $clog2(STABLE_CYC) + 1;
  // The run counter counts equal adjacent sample pairs; S samples give S-1 pairs.
  localparam logic [RUN_W-1:0] RUN_CAP = RUN_W'(STABLE_CYC - 2);
  localparam logic [RUN_W-1:0] RUN_SAT = RUN_W'(STABLE_CYC - 1);

  // Input stage and one-deep history of it.
  logic [2:0]       r_s_res;
  logic             r_s_sel;
  logic             r_s_vld;
  logic [2:0]       r_p_res;
  logic             r_p_sel;
  logic             r_p_vld;
  logic [RUN_W-1:0] r_run;

  state_t           r_state;
  logic [1:0]       r_phase;
  logic             r_valid;
  logic [2:0]       r_dice_value;
  logic             r_dice_new;
  logic             r_dice_err;
  logic             r_seq_err;
  logic [CNT_W-1:0] r_throw_cnt;
  logic [CNT_W-1:0] r_cycle_cnt;

  logic             w_eq;
  logic             w_cap;
  logic             w_dice_legal;
  logic             w_code_ok;
  logic [1:0]       w_code_phase;
  logic [1:0]       w_next_phase;
  logic             w_resync;
  logic             w_hold;
  logic             w_adv;
  logic             w_seq_set;
  logic             w_dice_set;

  function automatic state_t phase_state(input logic [1:0] ph);
    state_t st;
    case (ph)
      2'b00:   st = ST_RED;
      2'b01:   st = ST_RED_AMBER;
      2'b10:   st = ST_GREEN;
      default: st = ST_AMBER;
    endcase
    return st;
  endfunction

  always_comb begin
    // r_p_vld keeps the reset value of the input stage from counting as a sample.
    w_eq         = r_p_vld && !r_s_sel && !r_p_sel && (r_s_res == r_p_res);
    w_cap        = w_eq && (r_run == RUN_CAP);
    w_dice_legal = (r_s_res != 3'd0) && (r_s_res != 3'd7);

    w_code_ok    = 1'b1;
    w_code_phase = 2'b00;
    case (r_s_res)
      3'b001:  w_code_phase = 2'b00;
      3'b011:  w_code_phase = 2'b01;
      3'b100:  w_code_phase = 2'b10;
      3'b010:  w_code_phase = 2'b11;
      default: w_code_ok    = 1'b0;
    endcase

    w_next_phase = r_phase + 2'd1;
    // After any dice sample the lights ran unobserved, so re-acquire instead of checking order.
    w_resync     = (r_state == ST_UNSYNC) || !r_p_sel;
    w_hold       = w_code_ok && (w_code_phase == r_phase);
    w_adv        = w_code_ok && (w_code_phase == w_next_phase);
    w_seq_set    = r_s_sel && !w_resync && !w_hold && !w_adv;
    w_dice_set   = w_cap && !w_dice_legal;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_s_res      <= '0;
      r_s_sel      <= 1'b0;
      r_s_vld      <= 1'b0;
      r_p_res      <= '0;
      r_p_sel      <= 1'b0;
      r_p_vld      <= 1'b0;
      r_run        <= '0;
      r_state      <= ST_UNSYNC;
      r_phase      <= 2'b00;
      r_valid      <= 1'b0;
      r_dice_value <= '0;
      r_dice_new   <= 1'b0;
      r_dice_err   <= 1'b0;
      r_seq_err    <= 1'b0;
      r_throw_cnt  <= '0;
      r_cycle_cnt  <= '0;
    end else begin
      r_s_res <= io_bus.result;
      r_s_sel <= io_bus.sel;
      r_s_vld <= 1'b1;
      r_p_res <= r_s_res;
      r_p_sel <= r_s_sel;
      r_p_vld <= r_s_vld;

      // Saturate so a long run never reaches the capture point a second time.
      if (!w_eq)                r_run <= '0;
      else if (r_run != RUN_SAT) r_run <= r_run + RUN_W'(1);

      r_dice_new <= 1'b0;
      if (w_cap && w_dice_legal) begin
        r_dice_value <= r_s_res;
        r_dice_new   <= 1'b1;
        r_throw_cnt  <= r_throw_cnt + CNT_W'(1);
      end

      // A new error in the clearing cycle keeps the flag set.
      r_dice_err <= w_dice_set || (r_dice_err && !io_bus.clr_err);
      r_seq_err  <= w_seq_set  || (r_seq_err  && !io_bus.clr_err);

      if (r_s_sel) begin
        if (w_resync) begin
          if (w_code_ok) begin
            r_state <= phase_state(w_code_phase);
            r_phase <= w_code_phase;
            r_valid <= 1'b1;
          end else begin
            r_state <= ST_UNSYNC;
            r_valid <= 1'b0;
          end
        end else if (w_adv) begin
          r_state <= phase_state(w_next_phase);
          r_phase <= w_next_phase;
          if (r_phase == 2'b11) r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
        end else if (!w_hold) begin
          r_state <= ST_UNSYNC;
          r_valid <= 1'b0;
        end
      end
    end
  end

  assign io_bus.dice_value  = r_dice_value;
  assign io_bus.dice_new    = r_dice_new;
  assign io_bus.dice_err    = r_dice_err;
  assign io_bus.light_phase = r_phase;
  assign io_bus.light_valid = r_valid;
  assign io_bus.seq_err     = r_seq_err;
  assign io_bus.throw_cnt   = r_throw_cnt;
  assign io_bus.cycle_cnt   = r_cycle_cnt;

endmodule
